game_timer: RTL and testbench

Countdown game timer and 4-digit seven-segment display driver. It consumes the 1 Hz and 128 Hz single-cycle enable pulses produced by the design's clock divider and counts a game round down in MM:SS BCD. It signals round expiry to the game FSM and multiplexes the digits onto the board's common-anode display. It is the consumer end of the divider's tick interface and is gated by the same 2-bit game `state` bus.

---
 rtl/game_timer.sv | 164 ++++++++++++++++
 tb/tb_game_timer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// Countdown game timer (MM:SS, BCD) with a 4-digit common-anode display mux.
// Counts down on 1 Hz ticks while in the game state and flags expiry.
// After expiry it blinks the display on each 1 Hz tick.
// All outputs are registered.
module game_timer #(
  parameter int unsigned START_MIN   = 1,
  parameter int unsigned START_SEC   = 30,
  parameter logic [1:0]  STATE_RESET = 2'b00,
  parameter logic [1:0]  STATE_GAME  = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] state,
  input  logic       one_hz_tick,
  input  logic       display_tick,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       time_up,
  output logic       time_up_pulse
);

  localparam logic [3:0] MtInit = 4'(START_MIN / 10);
  localparam logic [3:0] MoInit = 4'(START_MIN % 10);
  localparam logic [3:0] StInit = 4'(START_SEC / 10);
  localparam logic [3:0] SoInit = 4'(START_SEC % 10);

  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic       time_up_q, time_up_d;
  logic       pulse_q, pulse_d;
  logic       blink_q, blink_d;
  logic       is_zero;

  logic [1:0] idx_q;
  logic [6:0] seg_q;
  logic [3:0] an_q, an_sel_q, an_d, anode;
  logic       dp_q;
  logic [3:0] digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  assign is_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);

  // Next count, expiry flag and blink state; reload wins over any tick.
  always_comb begin
    mt_d      = mt_q;
    mo_d      = mo_q;
    st_d      = st_q;
    so_d      = so_q;
    time_up_d = time_up_q;
    blink_d   = blink_q;
    pulse_d   = 1'b0;
    if (state == STATE_RESET) begin
      mt_d      = MtInit;
      mo_d      = MoInit;
      st_d      = StInit;
      so_d      = SoInit;
      time_up_d = 1'b0;
      blink_d   = 1'b0;
    end else if (state == STATE_GAME) begin
      if (one_hz_tick && !is_zero) begin
        if (so_q != 4'd0) begin
          so_d = so_q - 4'd1;
        end else begin
          so_d = 4'd9;
          if (st_q != 4'd0) begin
            st_d = st_q - 4'd1;
          end else begin
            st_d = 4'd5;
            if (mo_q != 4'd0) begin
              mo_d = mo_q - 4'd1;
            end else begin
              // Count is non-zero here, so mt_q is non-zero.
              mo_d = 4'd9;
              mt_d = mt_q - 4'd1;
            end
          end
        end
      end
      if (is_zero && !time_up_q) begin
        time_up_d = 1'b1;
        pulse_d   = 1'b1;
      end else if (time_up_q && one_hz_tick) begin
        blink_d = ~blink_q;
      end
    end
  end

  // Count and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mt_q      <= MtInit;
      mo_q      <= MoInit;
      st_q      <= StInit;
      so_q      <= SoInit;
      time_up_q <= 1'b0;
      pulse_q   <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      mt_q      <= mt_d;
      mo_q      <= mo_d;
      st_q      <= st_d;
      so_q      <= so_d;
      time_up_q <= time_up_d;
      pulse_q   <= pulse_d;
      blink_q   <= blink_d;
    end
  end

  // Digit select for the current mux index; blanking follows blink immediately.
  always_comb begin
    digit = so_q;
    case (idx_q)
      2'd0: digit = so_q;
      2'd1: digit = st_q;
      2'd2: digit = mo_q;
      2'd3: digit = mt_q;
      default: digit = so_q;
    endcase
    anode = ~(4'b0001 << idx_q);
    an_d  = blink_d ? 4'hF : (display_tick ? anode : an_sel_q);
  end

  // Display mux registers: latch the current digit, then advance the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= 2'd0;
      seg_q    <= 7'h7F;
      an_sel_q <= 4'hF;
      an_q     <= 4'hF;
      dp_q     <= 1'b1;
    end else begin
      if (display_tick) begin
        idx_q    <= idx_q + 2'd1;
        seg_q    <= seg_decode(digit);
        an_sel_q <= anode;
        dp_q     <= (idx_q != 2'd2);
      end
      an_q <= an_d;
    end
  end

  assign seg           = seg_q;
  assign an            = an_q;
  assign dp            = dp_q;
  assign time_up       = time_up_q;
  assign time_up_pulse = pulse_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: table of tick counts vs. expected display contents, plus
// hand-written sequences for expiry timing, blink, pause/priority and async reset.
module tb_game_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] state = 2'b00;
  logic       one_hz_tick = 1'b0;
  logic       display_tick = 1'b0;

  logic [6:0] seg0, seg1;
  logic [3:0] an0, an1;
  logic       dp0, dp1, tu0, tu1, tp0, tp1;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] SReset = 2'b00;
  localparam logic [1:0] SGame  = 2'b01;
  localparam logic [1:0] SPause = 2'b10;

  always #5 clk = ~clk;

  game_timer dut (
    .clk(clk), .rst_n(rst_n), .state(state), .one_hz_tick(one_hz_tick),
    .display_tick(display_tick), .seg(seg0), .an(an0), .dp(dp0),
    .time_up(tu0), .time_up_pulse(tp0)
  );

  game_timer #(.START_MIN(10), .START_SEC(0)) dut10 (
    .clk(clk), .rst_n(rst_n), .state(state), .one_hz_tick(one_hz_tick),
    .display_tick(display_tick), .seg(seg1), .an(an1), .dp(dp1),
    .time_up(tu1), .time_up_pulse(tp1)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  typedef struct {
    int          ticks;
    logic [15:0] bcd;
    logic        tu;
    logic        bl;
  } vec_t;

  disp_t exp_q[$];

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    one_hz_tick  = 1'b0;
    display_tick = 1'b0;
    state        = SReset;
    rst_n        = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      one_hz_tick = 1'b1;
      step();
      one_hz_tick = 1'b0;
      step();
    end
  endtask

  // Expected display values are queued when the display tick is driven and
  // compared when the registered outputs appear one cycle later.
  task automatic read_display(input bit which, input logic [15:0] bcd, input logic bl,
                              input int first, input int last);
    disp_t e, g;
    for (int i = first; i <= last; i++) begin
      e.an  = bl ? 4'hF : ~(4'b0001 << i);
      e.seg = seg_ref(bcd[4*i +: 4]);
      e.dp  = (i == 2) ? 1'b0 : 1'b1;
      exp_q.push_back(e);
      display_tick = 1'b1;
      step();
      display_tick = 1'b0;
      g = exp_q.pop_front();
      check($sformatf("an[d%0d,u%0d]", i, which), which ? an1 : an0, g.an);
      check($sformatf("seg[d%0d,u%0d]", i, which), which ? seg1 : seg0, g.seg);
      check($sformatf("dp[d%0d,u%0d]", i, which), which ? dp1 : dp0, g.dp);
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    vecs[0]  = '{0,  16'h0130, 1'b0, 1'b0};
    vecs[1]  = '{1,  16'h0129, 1'b0, 1'b0};
    vecs[2]  = '{9,  16'h0121, 1'b0, 1'b0};
    vecs[3]  = '{10, 16'h0120, 1'b0, 1'b0};
    vecs[4]  = '{30, 16'h0100, 1'b0, 1'b0};
    vecs[5]  = '{31, 16'h0059, 1'b0, 1'b0};
    vecs[6]  = '{60, 16'h0030, 1'b0, 1'b0};
    vecs[7]  = '{89, 16'h0001, 1'b0, 1'b0};
    vecs[8]  = '{90, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{91, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{92, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{95, 16'h0000, 1'b1, 1'b1};

    // Async reset values, observed before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_an", an0, 4'hF);
    check("rst_seg", seg0, 7'h7F);
    check("rst_dp", dp0, 1'b1);
    check("rst_time_up", tu0, 1'b0);
    check("rst_pulse", tp0, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // Table: N ticks from reload, pause, then read all four digits.
    foreach (vecs[v]) begin
      do_reset();
      state = SGame;
      tick(vecs[v].ticks);
      state = SPause;
      step();
      check($sformatf("time_up[v%0d]", v), tu0, vecs[v].tu);
      check($sformatf("pulse[v%0d]", v), tp0, 1'b0);
      read_display(1'b0, vecs[v].bcd, vecs[v].bl, 0, 3);
    end

    // Expiry timing and blink.
    do_reset();
    state = SGame;
    tick(89);
    read_display(1'b0, 16'h0001, 1'b0, 0, 0);
    one_hz_tick = 1'b1;
    step();
    one_hz_tick = 1'b0;
    check("exp_T1_time_up", tu0, 1'b0);
    check("exp_T1_pulse", tp0, 1'b0);
    step();
    check("exp_T2_time_up", tu0, 1'b1);
    check("exp_T2_pulse", tp0, 1'b1);
    step();
    check("exp_T3_time_up", tu0, 1'b1);
    check("exp_T3_pulse", tp0, 1'b0);
    one_hz_tick = 1'b1;
    step();
    one_hz_tick = 1'b0;
    check("blink_on_an", an0, 4'hF);
    step();
    one_hz_tick = 1'b1;
    step();
    one_hz_tick = 1'b0;
    check("blink_off_an", an0, 4'hE);
    check("blink_pulse", tp0, 1'b0);
    read_display(1'b0, 16'h0000, 1'b0, 1, 3);

    // Pause holds, resume without extra decrement, reload beats a tick.
    do_reset();
    state = SGame;
    tick(1);
    state = SPause;
    tick(3);
    read_display(1'b0, 16'h0129, 1'b0, 0, 3);
    state = SGame;
    repeat (5) step();
    read_display(1'b0, 16'h0129, 1'b0, 0, 3);
    state       = SReset;
    one_hz_tick = 1'b1;
    step();
    one_hz_tick = 1'b0;
    state       = SPause;
    step();
    read_display(1'b0, 16'h0130, 1'b0, 0, 3);

    // Borrow across the minutes tens digit.
    do_reset();
    read_display(1'b1, 16'h1000, 1'b0, 0, 3);
    state = SGame;
    tick(1);
    read_display(1'b1, 16'h0959, 1'b0, 0, 3);

    // Async reset between edges at 00:42.
    do_reset();
    state = SGame;
    tick(48);
    state = SPause;
    read_display(1'b0, 16'h0042, 1'b0, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_an", an0, 4'hF);
    check("async_seg", seg0, 7'h7F);
    check("async_dp", dp0, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    read_display(1'b0, 16'h0130, 1'b0, 0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
